// File: rtl/unidad_siguiente_pc_pkg.sv
// Shared types for the next-PC unit: FSM states, branch mode encoding, alignment mask.
package pkg_siguiente_pc;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_TRAP = 2'd3
  } state_e;

  typedef enum logic {
    MODE_PC_REL  = 1'b0,
    MODE_REG_REL = 1'b1
  } mode_e;

  // Low target bits that must be zero for a 32-bit instruction fetch
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/unidad_siguiente_pc_sumador.sv
// Branch/jump target adder: PC-relative with scaled offset, or JALR (rs1+off with bit0 cleared).
// Purely combinational; wraps modulo 2^XLEN.
module sumador_branch_param
  import pkg_siguiente_pc::*;
#(
  parameter int XLEN         = 32,
  parameter int OFFSET_SHIFT = 1
) (
  input  logic            mode,
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] offset,
  output logic [XLEN-1:0] target
);

  localparam logic [XLEN-1:0] CLR_BIT0 = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0] sum_rel;
  logic [XLEN-1:0] sum_reg;

  always_comb begin
    sum_rel = base + (offset << OFFSET_SHIFT);
    sum_reg = (rs1 + offset) & CLR_BIT0;
    target  = (mode_e'(mode) == MODE_REG_REL) ? sum_reg : sum_rel;
  end

endmodule

// File: rtl/unidad_siguiente_pc.sv
// Fetch-stage next-PC unit: holds PC, applies branches one cycle after resolution.
// A redirect seen while stalled is parked (youngest wins) and applied on release; misaligned targets trap.
module unidad_siguiente_pc
  import pkg_siguiente_pc::*;
#(
  parameter int              XLEN         = 32,
  parameter int              OFFSET_SHIFT = 1,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              ALIGN_CHECK  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_valid,
  input  logic            branch_taken,
  input  logic            branch_mode,
  input  logic [XLEN-1:0] branch_base,
  input  logic [XLEN-1:0] branch_rs1,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            trap_ack,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] apply_tgt;
  logic            apply_vld;
  logic            taken;

  function automatic logic misaligned(input logic [XLEN-1:0] t);
    return (ALIGN_CHECK != 0) && ((t[1:0] & ALIGN_MASK) != 2'b00);
  endfunction

  sumador_branch_param #(
    .XLEN         (XLEN),
    .OFFSET_SHIFT (OFFSET_SHIFT)
  ) u_sumador (
    .mode   (branch_mode),
    .base   (branch_base),
    .rs1    (branch_rs1),
    .offset (branch_offset),
    .target (target)
  );

  assign taken = branch_valid & branch_taken;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    misalign_d = misalign_q;
    bad_addr_d = bad_addr_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    apply_vld  = 1'b0;
    apply_tgt  = target;

    case (state_q)
      ST_BOOT: begin
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
      end
      ST_RUN: begin
        if (stall) begin
          state_d = ST_HOLD;
          if (taken) begin
            pend_d     = 1'b1;
            pend_tgt_d = target;
          end
        end else if (taken) begin
          apply_vld = 1'b1;
        end else begin
          pc_d = pc_q + XLEN'(INC);
        end
      end
      ST_HOLD: begin
        if (stall) begin
          if (taken) begin
            pend_d     = 1'b1;
            pend_tgt_d = target;
          end
        end else begin
          state_d = ST_RUN;
          pend_d  = 1'b0;
          // A branch resolving on the release cycle is younger than the parked one
          if (taken) begin
            apply_vld = 1'b1;
          end else if (pend_q) begin
            apply_vld = 1'b1;
            apply_tgt = pend_tgt_q;
          end else begin
            pc_d = pc_q + XLEN'(INC);
          end
        end
      end
      ST_TRAP: begin
        if (trap_ack) begin
          state_d    = ST_RUN;
          pc_d       = trap_vector;
          pc_valid_d = 1'b1;
          misalign_d = 1'b0;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (apply_vld) begin
      if (misaligned(apply_tgt)) begin
        state_d    = ST_TRAP;
        pc_valid_d = 1'b0;
        misalign_d = 1'b1;
        bad_addr_d = apply_tgt;
        pend_d     = 1'b0;
      end else begin
        pc_d = apply_tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc_valid    = pc_valid_q;
  assign pc_plus_inc = pc_q + XLEN'(INC);
  assign misalign    = misalign_q;
  assign bad_addr    = bad_addr_q;

endmodule
